// File: rtl/ctx_stack_ctrl_if.sv
`default_nettype none
//----------------------------------------------------------------------
// ctx_stack_ctrl_if : call/return request handshake bundle
// Rev 1.0
//----------------------------------------------------------------------
interface ctx_stack_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_is_call;
  logic [WIDTH-1:0] req_ctx;

  modport master (
    output req_valid,
    output req_is_call,
    output req_ctx,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_is_call,
    input  req_ctx,
    output req_ready
  );
endinterface
`default_nettype wire

// File: rtl/ctx_stack_ctrl.sv
`default_nettype none
//----------------------------------------------------------------------
// ctx_stack_ctrl : call/return context controller in front of a lifo
// Rev 1.0
//----------------------------------------------------------------------
module ctx_stack_ctrl #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 32,
  parameter int               CNT_W     = 6,
  parameter logic [WIDTH-1:0] CTX_RESET = '0
) (
  input  wire logic             clk,
  input  wire logic             reset,
  ctx_stack_ctrl_if.slave       req,
  output logic [WIDTH-1:0]      ctx,
  output logic                  done,
  output logic [CNT_W-1:0]      depth_cnt,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic                  err_desync,
  input  wire logic             err_clear,
  output logic                  lifo_push,
  output logic [WIDTH-1:0]      lifo_push_data,
  output logic                  lifo_pop,
  input  wire logic [WIDTH-1:0] lifo_tos,
  input  wire logic             lifo_empty_n
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PUSH   = 2'd1,
    POP    = 2'd2,
    SETTLE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] pending_ctx;
  logic             accept;
  logic             load_pending;
  logic             ovf_set;
  logic             unf_set;
  logic             desync_set;
  logic             is_full;
  logic             is_empty;

  assign is_full        = (depth_cnt == CNT_FULL);
  assign is_empty       = (depth_cnt == '0);
  assign req.req_ready  = (state == IDLE);
  assign accept         = req.req_valid & (state == IDLE);
  assign lifo_push_data = ctx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    load_pending = 1'b0;
    ovf_set      = 1'b0;
    unf_set      = 1'b0;
    desync_set   = 1'b0;
    done         = 1'b0;
    lifo_push    = 1'b0;
    lifo_pop     = 1'b0;
    case (state)
      IDLE: begin
        // the lifo flag only has to agree with our count while nothing is in flight
        desync_set = (lifo_empty_n != !is_empty);
        if (accept) begin
          if (req.req_is_call) begin
            if (is_full) begin
              ovf_set  = 1'b1;
              state_nx = SETTLE;
            end else begin
              load_pending = 1'b1;
              state_nx     = PUSH;
            end
          end else if (is_empty) begin
            unf_set  = 1'b1;
            state_nx = SETTLE;
          end else begin
            state_nx = POP;
          end
        end
      end
      PUSH: begin
        lifo_push = 1'b1;
        state_nx  = SETTLE;
      end
      POP: begin
        lifo_pop = 1'b1;
        state_nx = SETTLE;
      end
      SETTLE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctx         <= CTX_RESET;
      pending_ctx <= '0;
      depth_cnt   <= '0;
    end else begin
      if (load_pending) begin
        pending_ctx <= req.req_ctx;
      end
      // lifo_tos still shows the pre-pop top at the pop edge
      if (state == PUSH) begin
        ctx       <= pending_ctx;
        depth_cnt <= depth_cnt + CNT_W'(1);
      end else if (state == POP) begin
        ctx       <= lifo_tos;
        depth_cnt <= depth_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_desync    <= 1'b0;
    end else begin
      if (ovf_set) begin
        err_overflow <= 1'b1;
      end else if (err_clear) begin
        err_overflow <= 1'b0;
      end
      if (unf_set) begin
        err_underflow <= 1'b1;
      end else if (err_clear) begin
        err_underflow <= 1'b0;
      end
      if (desync_set) begin
        err_desync <= 1'b1;
      end else if (err_clear) begin
        err_desync <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
